// File: rtl/bz_melody_sequencer.sv
// bz_melody_sequencer: steps a song ROM, drives beat decoder and tone PWM for each note
module bz_melody_sequencer #(
    parameter int ADDR_W     = 6,
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] song_len,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [3:0]        beat_code,
    input  logic [27:0]       beat_cnt_parameter,
    output logic [3:0]        tone_code,
    output logic              tone_valid,
    output logic              busy,
    output logic              done
);
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_LATCH, S_LOAD, S_PLAY, S_GAP, S_NEXT, S_END, S_DONE
    } state_t;

    localparam logic [27:0] GAP_LOAD = 28'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        beat_q, beat_d;
    logic [3:0]        tone_q, tone_d;
    logic              tv_q, tv_d;
    logic [27:0]       cnt_q, cnt_d;

    // State register; the duration counter doubles as the gap counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            beat_q  <= '0;
            tone_q  <= '0;
            tv_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            tone_q  <= tone_d;
            tv_q    <= tv_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath; stop overrides everything and returns to IDLE silently
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        tone_d  = tone_q;
        tv_d    = tv_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (start) begin
                addr_d  = '0;
                state_d = (song_len != '0) ? S_FETCH : S_DONE;
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                beat_d  = rom_data[3:0];
                tone_d  = rom_data[7:4];
                state_d = S_LOAD;
            end
            S_LOAD: if (beat_cnt_parameter == '0) state_d = S_END;
            else begin
                cnt_d   = beat_cnt_parameter - 28'd1;
                tv_d    = (tone_q != 4'd0);
                state_d = S_PLAY;
            end
            S_PLAY: if (cnt_q == '0) begin
                tv_d    = 1'b0;
                cnt_d   = GAP_LOAD;
                state_d = (GAP_CYCLES > 0) ? S_GAP : S_NEXT;
            end else cnt_d = cnt_q - 28'd1;
            S_GAP: if (cnt_q == '0) state_d = S_NEXT;
            else cnt_d = cnt_q - 28'd1;
            S_NEXT: if (addr_q == song_len - ADDR_W'(1)) state_d = S_END;
            else begin
                addr_d  = addr_q + ADDR_W'(1);
                state_d = S_FETCH;
            end
            S_END: if (loop_en && song_len != '0) begin
                addr_d  = '0;
                state_d = S_FETCH;
            end else state_d = S_DONE;
            S_DONE: begin
                tone_d  = 4'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (stop) begin
            state_d = S_IDLE;
            tv_d    = 1'b0;
            tone_d  = 4'd0;
        end
    end

    assign rom_addr   = addr_q;
    assign beat_code  = beat_q;
    assign tone_code  = tone_q;
    assign tone_valid = tv_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
endmodule

// File: tb/tb_bz_melody_sequencer.sv
// tb_bz_melody_sequencer: directed table-driven checks of the melody sequencer (no gap and 3-cycle gap)
module tb_bz_melody_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic start0 = 0, stop0 = 0, loop0 = 0;
    logic [5:0] len0 = 0, addr0;
    logic [7:0] rd0;
    logic [3:0] beat0, tone0;
    logic tv0, busy0, done0;
    logic [7:0] mem0 [64];

    logic start1 = 0, stop1 = 0, loop1 = 0;
    logic [5:0] len1 = 0, addr1;
    logic [7:0] rd1;
    logic [3:0] beat1, tone1;
    logic tv1, busy1, done1;
    logic [7:0] mem1 [64];

    function automatic logic [27:0] dec(input logic [3:0] b);
        case (b)
            4'd1: dec = 28'd64;
            4'd2: dec = 28'd32;
            4'd3: dec = 28'd16;
            4'd4: dec = 28'd8;
            4'd5: dec = 28'd4;
            4'd6: dec = 28'd2;
            default: dec = 28'd0;
        endcase
    endfunction

    always @(posedge clk) rd0 <= mem0[addr0];
    always @(posedge clk) rd1 <= mem1[addr1];

    bz_melody_sequencer #(.ADDR_W(6), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .stop(stop0), .loop_en(loop0),
        .song_len(len0), .rom_addr(addr0), .rom_data(rd0), .beat_code(beat0),
        .beat_cnt_parameter(dec(beat0)), .tone_code(tone0), .tone_valid(tv0),
        .busy(busy0), .done(done0));

    bz_melody_sequencer #(.ADDR_W(6), .GAP_CYCLES(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .stop(stop1), .loop_en(loop1),
        .song_len(len1), .rom_addr(addr1), .rom_data(rd1), .beat_code(beat1),
        .beat_cnt_parameter(dec(beat1)), .tone_code(tone1), .tone_valid(tv1),
        .busy(busy1), .done(done1));

    int total = 0, bad = 0;
    int tv_cnt, done_cnt, max_addr;

    typedef struct {
        int         t;
        logic       tv;
        logic [3:0] tone;
        logic       busy;
        logic       done;
        logic [5:0] addr;
    } vec_t;
    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        tv_cnt   += int'(tv0);
        done_cnt += int'(done0);
        if (int'(addr0) > max_addr) max_addr = int'(addr0);
    endtask

    task automatic clr();
        tv_cnt = 0;
        done_cnt = 0;
        max_addr = 0;
    endtask

    task automatic pulse_start0();
        clr();
        start0 = 1;
        tick();
        start0 = 0;
    endtask

    task automatic load_song0();
        foreach (mem0[i]) mem0[i] = 8'h00;
        mem0[0] = 8'h13;
        mem0[1] = 8'h25;
        mem0[2] = 8'h06;
    endtask

    initial begin
        logic prev;
        int r1, r2;
        tbl[0]  = '{0,  0, 4'd0, 1, 0, 6'd0};
        tbl[1]  = '{2,  0, 4'd1, 1, 0, 6'd0};
        tbl[2]  = '{3,  1, 4'd1, 1, 0, 6'd0};
        tbl[3]  = '{18, 1, 4'd1, 1, 0, 6'd0};
        tbl[4]  = '{19, 0, 4'd1, 1, 0, 6'd0};
        tbl[5]  = '{20, 0, 4'd1, 1, 0, 6'd1};
        tbl[6]  = '{23, 1, 4'd2, 1, 0, 6'd1};
        tbl[7]  = '{26, 1, 4'd2, 1, 0, 6'd1};
        tbl[8]  = '{27, 0, 4'd2, 1, 0, 6'd1};
        tbl[9]  = '{28, 0, 4'd2, 1, 0, 6'd2};
        tbl[10] = '{31, 0, 4'd0, 1, 0, 6'd2};
        tbl[11] = '{34, 0, 4'd0, 1, 0, 6'd2};
        tbl[12] = '{35, 0, 4'd0, 1, 1, 6'd2};
        tbl[13] = '{36, 0, 4'd0, 0, 0, 6'd2};
        load_song0();
        foreach (mem1[i]) mem1[i] = 8'h00;
        clr();

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_addr", addr0, 0);
        chk("rst_beat", beat0, 0);
        chk("rst_tone", tone0, 0);
        chk("rst_tv", tv0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        rst_n = 1;
        tick();

        // 1: three-note song, no loop
        len0 = 3;
        loop0 = 0;
        pulse_start0();
        for (int t = 0; t <= 40; t++) begin
            for (int i = 0; i < 14; i++) if (tbl[i].t == t) begin
                chk($sformatf("s1_tv@%0d", t), tv0, tbl[i].tv);
                chk($sformatf("s1_tone@%0d", t), tone0, tbl[i].tone);
                chk($sformatf("s1_busy@%0d", t), busy0, tbl[i].busy);
                chk($sformatf("s1_done@%0d", t), done0, tbl[i].done);
                chk($sformatf("s1_addr@%0d", t), addr0, tbl[i].addr);
            end
            tick();
        end
        chk("s1_tv_cycles", tv_cnt, 20);
        chk("s1_done_pulses", done_cnt, 1);
        chk("s1_max_addr", max_addr, 2);

        // 2: looping, then stop mid-PLAY
        loop0 = 1;
        pulse_start0();
        for (int t = 0; t < 40; t++) begin
            if (t == 35) begin
                chk("s2_wrap_addr", addr0, 0);
                chk("s2_wrap_busy", busy0, 1);
            end
            if (t == 38) begin
                chk("s2_loop_tv", tv0, 1);
                chk("s2_loop_tone", tone0, 1);
            end
            tick();
        end
        stop0 = 1;
        tick();
        stop0 = 0;
        chk("s2_stop_tv", tv0, 0);
        chk("s2_stop_busy", busy0, 0);
        chk("s2_stop_tone", tone0, 0);
        tick();
        chk("s2_no_done", done_cnt, 0);
        chk("s2_max_addr", max_addr, 2);
        loop0 = 0;

        // 3: end marker at entry 1
        mem0[1] = 8'h30;
        mem0[2] = 8'h24;
        pulse_start0();
        for (int t = 0; t <= 30; t++) begin
            if (t == 23) begin
                chk("s3_end_busy", busy0, 1);
                chk("s3_end_done", done0, 0);
            end
            if (t == 24) chk("s3_done", done0, 1);
            if (t == 25) chk("s3_idle", busy0, 0);
            tick();
        end
        chk("s3_done_pulses", done_cnt, 1);
        chk("s3_max_addr", max_addr, 1);
        chk("s3_tv_cycles", tv_cnt, 16);

        // 4: empty song
        len0 = 0;
        pulse_start0();
        chk("s4_done", done0, 1);
        chk("s4_busy", busy0, 1);
        tick();
        chk("s4_done_off", done0, 0);
        chk("s4_idle", busy0, 0);
        repeat (3) tick();
        chk("s4_tv_never", tv_cnt, 0);
        chk("s4_done_pulses", done_cnt, 1);

        // 5: gap of 3 cycles between notes
        mem1[0] = 8'h15;
        mem1[1] = 8'h25;
        len1 = 2;
        start1 = 1;
        tick();
        start1 = 0;
        prev = 0;
        r1 = -1;
        r2 = -1;
        for (int t = 0; t <= 26; t++) begin
            if (tv1 && !prev) begin
                if (r1 < 0) r1 = t;
                else if (r2 < 0) r2 = t;
            end
            prev = tv1;
            if (t == 6) chk("s5_last_play", tv1, 1);
            if (t >= 7 && t <= 9) begin
                chk($sformatf("s5_gap_tv@%0d", t), tv1, 0);
                chk($sformatf("s5_gap_addr@%0d", t), addr1, 0);
            end
            if (t == 11) chk("s5_next_addr", addr1, 1);
            if (t == 23) chk("s5_done", done1, 1);
            if (t == 24) chk("s5_idle", busy1, 0);
            tick();
        end
        chk("s5_first_rise", r1, 3);
        chk("s5_period", r2 - r1, 11);

        // 6: start while busy ignored
        load_song0();
        len0 = 3;
        pulse_start0();
        repeat (5) tick();
        start0 = 1;
        tick();
        start0 = 0;
        chk("s6_busy_tv", tv0, 1);
        chk("s6_busy_addr", addr0, 0);
        repeat (13) tick();
        chk("s6_note_end_tv", tv0, 0);
        tick();
        chk("s6_advance_addr", addr0, 1);
        stop0 = 1;
        tick();
        stop0 = 0;

        // start and stop together stay idle
        start0 = 1;
        stop0 = 1;
        tick();
        start0 = 0;
        stop0 = 0;
        chk("s6_ss_busy", busy0, 0);
        tick();
        chk("s6_ss_busy2", busy0, 0);
        chk("s6_ss_done", done0, 0);

        // async reset mid-note
        pulse_start0();
        repeat (5) tick();
        chk("s6_pre_rst_tv", tv0, 1);
        rst_n = 0;
        #2;
        chk("s6_rst_tv", tv0, 0);
        chk("s6_rst_tone", tone0, 0);
        chk("s6_rst_busy", busy0, 0);
        chk("s6_rst_beat", beat0, 0);
        rst_n = 1;
        tick();
        chk("s6_after_rst_busy", busy0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
